// File: rtl/visbuffer_pkg.sv
// Shared constants for the visibility chain and its ping-pong frame buffer.
// Visibility words are packed {real, imag}, with the real part in the MSBs.
package visbuffer_pkg;
    localparam int LOOP0     = 5;
    localparam int LOOP1     = 3;
    localparam int ACCUM     = 6;
    localparam int VIS_WIDTH = ACCUM;
    localparam int VIS_COUNT = LOOP0 * LOOP1;
    localparam int VIS_DBITS = 8;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;
endpackage

// File: rtl/visbuffer_if.sv
// Frame input strobes and the readout stream of visbuffer, bundled as one port.
interface visbuffer_if import visbuffer_pkg::*; #(
    parameter int WIDTH = VIS_WIDTH
) ();
    logic               vis_valid_i;
    logic               vis_first_i;
    logic               vis_last_i;
    logic [WIDTH-1:0]   vis_real_i;
    logic [WIDTH-1:0]   vis_imag_i;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [2*WIDTH-1:0] m_tdata;

    modport slave (
        input  vis_valid_i, vis_first_i, vis_last_i, vis_real_i, vis_imag_i, m_tready,
        output m_tvalid, m_tlast, m_tdata
    );

    modport master (
        output vis_valid_i, vis_first_i, vis_last_i, vis_real_i, vis_imag_i, m_tready,
        input  m_tvalid, m_tlast, m_tdata
    );
endinterface

// File: rtl/visbuffer_visram.sv
// Simple dual-port RAM holding both frame banks; address is {bank, index}.
module visram import visbuffer_pkg::*; #(
    parameter int DW = 2 * VIS_WIDTH,
    parameter int AW = $clog2(VIS_COUNT) + 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/visbuffer.sv
// Ping-pong frame buffer: captures visibility frames into two banks and
// streams completed frames out in commit order, dropping frames when both banks are full.
module visbuffer import visbuffer_pkg::*; #(
    parameter int WIDTH = VIS_WIDTH,
    parameter int COUNT = VIS_COUNT,
    parameter int DBITS = VIS_DBITS
) (
    input  logic             clock,
    input  logic             reset,
    visbuffer_if.slave       bus,
    output logic             overflow_o,
    output logic [DBITS-1:0] dropped_o
);
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int CW = $clog2(COUNT + 1);
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] COUNT_C = CW'(COUNT);

    wstate_t       wstate, wstate_next;
    rstate_t       rstate, rstate_next;
    logic [1:0]    full;
    logic [CW-1:0] len [2];
    logic          wbank, rbank;
    logic [CW-1:0] wcount, wcount_next;
    logic [CW-1:0] rcount, rcount_next;
    logic          we, commit, drop, bank_avail;
    logic [IW-1:0] widx, ridx;
    logic [CW-1:0] commit_len;
    logic          issue, issue_last, credit;
    logic [DW-1:0] rdata;
    logic          ram_valid, ram_last;
    logic [DW-1:0] ent_data [2];
    logic [1:0]    ent_last;
    logic          head, tail, pop, free_evt;
    logic [1:0]    cnt;
    logic [2:0]    occ;

    assign bus.m_tvalid = (cnt != 2'd0);
    assign bus.m_tdata  = ent_data[head];
    assign bus.m_tlast  = bus.m_tvalid & ent_last[head];
    assign pop          = bus.m_tvalid & bus.m_tready;
    assign free_evt     = pop & bus.m_tlast;
    // A bank released by the final transfer this edge can take a new frame on the same edge.
    assign bank_avail   = !full[wbank] || (free_evt && (rbank == wbank));
    assign occ          = 3'(cnt) + 3'(ram_valid) - 3'(pop);
    assign credit       = (occ < 3'd2);

    visram #(.DW(DW), .AW(IW + 1)) u_ram (
        .clock (clock),
        .we    (we),
        .waddr ({wbank, widx}),
        .wdata ({bus.vis_real_i, bus.vis_imag_i}),
        .re    (issue),
        .raddr ({rbank, ridx}),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_next;
            rstate <= rstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        if (bus.vis_valid_i) begin
            if (bus.vis_first_i)
                wstate_next = bus.vis_last_i ? W_IDLE : (bank_avail ? W_FILL : W_DROP);
            else if (bus.vis_last_i)
                wstate_next = W_IDLE;
        end
    end

    always_comb begin
        we          = 1'b0;
        widx        = '0;
        commit      = 1'b0;
        commit_len  = '0;
        drop        = 1'b0;
        wcount_next = wcount;
        if (bus.vis_valid_i && bus.vis_first_i) begin
            if (bank_avail) begin
                we          = 1'b1;
                wcount_next = CW'(1);
                commit      = bus.vis_last_i;
                commit_len  = CW'(1);
            end else begin
                drop = 1'b1;
            end
        end else if (bus.vis_valid_i && (wstate == W_FILL)) begin
            // Words past the bank depth are silently discarded; the frame still commits on last.
            if (wcount < COUNT_C) begin
                we          = 1'b1;
                widx        = wcount[IW-1:0];
                wcount_next = wcount + CW'(1);
            end
            commit     = bus.vis_last_i;
            commit_len = wcount_next;
        end
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (full[rbank] && credit) rstate_next = R_SEND;
            R_SEND:  if (free_evt) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        issue_last  = 1'b0;
        ridx        = '0;
        rcount_next = rcount;
        if (rstate == R_IDLE) begin
            if (full[rbank] && credit) begin
                issue       = 1'b1;
                issue_last  = (len[rbank] == CW'(1));
                rcount_next = CW'(1);
            end
        end else if (credit && (rcount < len[rbank])) begin
            issue       = 1'b1;
            ridx        = rcount[IW-1:0];
            issue_last  = ((rcount + CW'(1)) == len[rbank]);
            rcount_next = rcount + CW'(1);
        end
    end

    // Commit is applied after free so a bank released and refilled on one edge stays full.
    always_ff @(posedge clock) begin
        if (reset) begin
            full       <= '0;
            len[0]     <= '0;
            len[1]     <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wcount     <= '0;
            rcount     <= '0;
            overflow_o <= 1'b0;
            dropped_o  <= '0;
        end else begin
            wcount <= wcount_next;
            rcount <= rcount_next;
            if (free_evt) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
            if (commit) begin
                full[wbank] <= 1'b1;
                len[wbank]  <= commit_len;
                wbank       <= ~wbank;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (dropped_o != '1)
                    dropped_o <= dropped_o + 1'b1;
            end
        end
    end

    // Two-entry skid store behind the RAM read; issue is throttled so it never overflows.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_valid   <= 1'b0;
            ram_last    <= 1'b0;
            head        <= 1'b0;
            tail        <= 1'b0;
            cnt         <= 2'd0;
            ent_data[0] <= '0;
            ent_data[1] <= '0;
            ent_last    <= '0;
        end else begin
            ram_valid <= issue;
            ram_last  <= issue_last;
            if (ram_valid) begin
                ent_data[tail] <= rdata;
                ent_last[tail] <= ram_last;
                tail           <= ~tail;
            end
            if (pop)
                head <= ~head;
            cnt <= cnt + 2'(ram_valid) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_visbuffer.sv
// Scoreboard bench for visbuffer: a frame-level model predicts the output stream
// and drop counters; a separate monitor compares every transfer against it.
module tb_visbuffer;
    import visbuffer_pkg::*;

    localparam int W  = VIS_WIDTH;
    localparam int N  = VIS_COUNT;
    localparam int DB = VIS_DBITS;

    logic          clock = 1'b0;
    logic          reset;
    logic          overflow_o;
    logic [DB-1:0] dropped_o;

    visbuffer_if #(.WIDTH(W)) bus ();

    visbuffer #(.WIDTH(W), .COUNT(N), .DBITS(DB)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .overflow_o (overflow_o),
        .dropped_o  (dropped_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [2*W:0]   expq [$];
    logic [2*W-1:0] cur [$];
    bit  in_frame = 0;
    int  held = 0;
    int  model_drops = 0;
    bit  model_overflow = 0;
    int  words_rx = 0;
    int  frames_rx = 0;
    int  words_in_frame = 0;
    int  ready_mode = 1;
    bit  toggle = 0;
    bit  prev_reset = 1;
    bit  stall_prev = 0;
    logic [2*W-1:0] prev_data;
    logic           prev_last;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: condition not met at %0t", name, $time);
    endtask

    task automatic applyStimulus(input bit valid, input bit first, input bit last,
                                 input logic [W-1:0] re, input logic [W-1:0] im);
        bus.vis_valid_i = valid;
        bus.vis_first_i = first;
        bus.vis_last_i  = last;
        bus.vis_real_i  = re;
        bus.vis_imag_i  = im;
        @(posedge clock);
        #1;
        bus.vis_valid_i = 1'b0;
        bus.vis_first_i = 1'b0;
        bus.vis_last_i  = 1'b0;
    endtask

    task automatic sendFrame(input int len, input bit rnd, input bit with_last);
        for (int i = 0; i < len; i++) begin
            if (rnd)
                applyStimulus(1'b1, i == 0, with_last && (i == len - 1), W'($urandom), W'($urandom));
            else
                applyStimulus(1'b1, i == 0, with_last && (i == len - 1), W'(i), W'(N - i));
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || bus.m_tvalid) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= budget)
            failNow("drain_timeout");
    endtask

    // Frame-level reference: a frame is kept if fewer than two committed frames are still unread.
    always @(negedge clock) begin
        if (reset) begin
            expq.delete();
            cur.delete();
            in_frame       = 0;
            held           = 0;
            model_drops    = 0;
            model_overflow = 0;
        end else begin
            checkOutput("overflow", 32'(overflow_o), 32'(model_overflow));
            checkOutput("dropped", 32'(dropped_o), 32'(model_drops));
            if (bus.m_tvalid && bus.m_tready && bus.m_tlast)
                held--;
            if (bus.vis_valid_i) begin
                if (bus.vis_first_i) begin
                    if (held < 2) begin
                        cur.delete();
                        cur.push_back({bus.vis_real_i, bus.vis_imag_i});
                        in_frame = 1;
                    end else begin
                        model_overflow = 1;
                        if (model_drops < (1 << DB) - 1)
                            model_drops++;
                        in_frame = 0;
                    end
                end else if (in_frame && cur.size() < N) begin
                    cur.push_back({bus.vis_real_i, bus.vis_imag_i});
                end
                if (bus.vis_last_i && in_frame) begin
                    for (int i = 0; i < cur.size(); i++)
                        expq.push_back({i == cur.size() - 1, cur[i]});
                    held++;
                    in_frame = 0;
                end
            end
        end
    end

    always @(negedge clock) begin : monitor
        logic [2*W:0] exp_word;
        if (reset) begin
            prev_reset     = 1;
            stall_prev     = 0;
            words_in_frame = 0;
        end else begin
            if (prev_reset) begin
                checkOutput("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
                checkOutput("rst_tlast", 32'(bus.m_tlast), 32'd0);
                checkOutput("rst_tdata", 32'(bus.m_tdata), 32'd0);
            end
            if (stall_prev) begin
                checkOutput("hold_tvalid", 32'(bus.m_tvalid), 32'd1);
                checkOutput("hold_tdata", 32'(bus.m_tdata), 32'(prev_data));
                checkOutput("hold_tlast", 32'(bus.m_tlast), 32'(prev_last));
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (expq.size() == 0) begin
                    failNow("unexpected_word");
                end else begin
                    exp_word = expq.pop_front();
                    checkOutput("tdata", 32'(bus.m_tdata), 32'(exp_word[2*W-1:0]));
                    checkOutput("tlast", 32'(bus.m_tlast), 32'(exp_word[2*W]));
                end
                words_rx++;
                words_in_frame++;
                if (bus.m_tlast) begin
                    frames_rx++;
                    words_in_frame = 0;
                end
            end
            stall_prev = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;
            prev_reset = 0;
        end
    end

    initial begin
        bus.m_tready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.m_tready = 1'b0;
                1:       bus.m_tready = 1'b1;
                2: begin
                    toggle       = ~toggle;
                    bus.m_tready = toggle;
                end
                default: bus.m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wb, fb, n;
        reset           = 1'b1;
        bus.vis_valid_i = 1'b0;
        bus.vis_first_i = 1'b0;
        bus.vis_last_i  = 1'b0;
        bus.vis_real_i  = '0;
        bus.vis_imag_i  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single 15-word frame, ready high: two-cycle latency then an unbroken burst.
        wb = words_rx; fb = frames_rx;
        sendFrame(N, 1'b0, 1'b1);
        @(negedge clock); checkOutput("lat_cycle0", 32'(bus.m_tvalid), 32'd0);
        @(negedge clock); checkOutput("lat_cycle1", 32'(bus.m_tvalid), 32'd0);
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            checkOutput("burst_valid", 32'(bus.m_tvalid), 32'd1);
            @(negedge clock);
        end
        checkOutput("burst_end", 32'(bus.m_tvalid), 32'd0);
        @(posedge clock); #1;
        waitDrain(50);
        checkOutput("t1_words", 32'(words_rx - wb), 32'd15);
        checkOutput("t1_frames", 32'(frames_rx - fb), 32'd1);

        // Same frame with ready toggling.
        ready_mode = 2;
        wb = words_rx;
        sendFrame(N, 1'b0, 1'b1);
        waitDrain(100);
        checkOutput("t2_words", 32'(words_rx - wb), 32'd15);

        // Resync: first reasserted at word 6.
        ready_mode = 1;
        wb = words_rx; fb = frames_rx;
        sendFrame(6, 1'b1, 1'b0);
        sendFrame(N, 1'b1, 1'b1);
        waitDrain(100);
        checkOutput("t3_words", 32'(words_rx - wb), 32'd15);
        checkOutput("t3_frames", 32'(frames_rx - fb), 32'd1);
        checkOutput("t3_dropped", 32'(dropped_o), 32'd0);

        // Short frame, then an overlong one truncated to the bank depth.
        wb = words_rx; fb = frames_rx;
        sendFrame(4, 1'b1, 1'b1);
        sendFrame(20, 1'b1, 1'b1);
        waitDrain(100);
        checkOutput("t4_words", 32'(words_rx - wb), 32'd19);
        checkOutput("t4_frames", 32'(frames_rx - fb), 32'd2);

        // Three back-to-back frames against a stalled consumer: the third is dropped.
        ready_mode = 0;
        repeat (2) begin @(posedge clock); #1; end
        wb = words_rx; fb = frames_rx;
        for (int f = 0; f < 3; f++)
            sendFrame(N, 1'b1, 1'b1);
        repeat (4) begin @(posedge clock); #1; end
        checkOutput("t5_overflow", 32'(overflow_o), 32'd1);
        checkOutput("t5_dropped", 32'(dropped_o), 32'd1);
        checkOutput("t5_stalled_valid", 32'(bus.m_tvalid), 32'd1);
        ready_mode = 1;
        waitDrain(100);
        checkOutput("t5_words", 32'(words_rx - wb), 32'd30);
        checkOutput("t5_frames", 32'(frames_rx - fb), 32'd2);

        // Reset in the middle of a readout.
        sendFrame(N, 1'b1, 1'b1);
        n = 0;
        while (words_in_frame < 7 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50)
            failNow("t6_wait_word7");
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6_tvalid", 32'(bus.m_tvalid), 32'd0);
        checkOutput("t6_dropped", 32'(dropped_o), 32'd0);
        checkOutput("t6_overflow", 32'(overflow_o), 32'd0);
        @(posedge clock); #1;
        wb = words_rx;
        sendFrame(N, 1'b1, 1'b1);
        waitDrain(100);
        checkOutput("t6_words", 32'(words_rx - wb), 32'd15);

        // Randomised traffic: stray words, partial frames, random lengths and back-pressure.
        ready_mode = 3;
        for (int f = 0; f < 14; f++) begin
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) != 0)
                    applyStimulus(1'b1, 1'b0, $urandom_range(0, 1) != 0, W'($urandom), W'($urandom));
                else
                    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if ($urandom_range(0, 3) == 0)
                sendFrame($urandom_range(1, 5), 1'b1, 1'b0);
            sendFrame($urandom_range(1, 20), 1'b1, 1'b1);
        end
        ready_mode = 1;
        waitDrain(400);
        checkOutput("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
